// File: rtl/lpgbt_uplink_frame_capture_if.sv
// Register-layer side of the uplink frame capture block: frame stream in,
// capture control, buffer readout and link statistics out.
interface lpgbt_uplink_frame_capture_if #(
   parameter int DEPTH   = 16,
   parameter int FADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
   logic                 frame_valid_i;
   logic [233:0]         frame_data_i;
   logic                 uplinkrdy_i;
   logic                 uplinkFEC_i;
   logic                 arm_i;
   logic                 abort_i;
   logic [1:0]           trig_mode_i;
   logic [31:0]          match_mask_i;
   logic [31:0]          match_value_i;
   logic                 clear_cnt_i;
   logic [FADDR_W+2:0]   rd_addr_i;
   logic [31:0]          rd_data_o;
   logic [1:0]           state_o;
   logic [FADDR_W:0]     frames_captured_o;
   logic [15:0]          fec_err_cnt_o;
   logic [15:0]          rdy_loss_cnt_o;

   modport master (
      output frame_valid_i, frame_data_i, uplinkrdy_i, uplinkFEC_i, arm_i, abort_i,
             trig_mode_i, match_mask_i, match_value_i, clear_cnt_i, rd_addr_i,
      input  rd_data_o, state_o, frames_captured_o, fec_err_cnt_o, rdy_loss_cnt_o
   );

   modport slave (
      input  frame_valid_i, frame_data_i, uplinkrdy_i, uplinkFEC_i, arm_i, abort_i,
             trig_mode_i, match_mask_i, match_value_i, clear_cnt_i, rd_addr_i,
      output rd_data_o, state_o, frames_captured_o, fec_err_cnt_o, rdy_loss_cnt_o
   );
endinterface

// File: rtl/lpgbt_uplink_frame_capture.sv
// Triggered burst capture of 234-bit lpGBT uplink frames into a DEPTH-deep
// buffer with 32-bit registered readout, plus saturating link statistics.
module lpgbt_uplink_frame_capture #(
   parameter int DEPTH = 16
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESETN,
   lpgbt_uplink_frame_capture_if.slave    bus
);
   localparam int FADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [FADDR_W:0] DEPTH_C = (FADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e               state_q;
   logic [FADDR_W:0]     count_q;
   logic [233:0]         mem_q [DEPTH];
   logic [31:0]          rd_data_q, rd_data_d;
   logic [15:0]          fec_q, fec_d;
   logic [15:0]          loss_q, loss_d;
   logic                 rdy_q;

   logic                 accepted;
   logic                 trig;
   logic                 wr_en;
   logic [FADDR_W-1:0]   wr_slot;
   logic [FADDR_W-1:0]   rd_frame;
   logic [2:0]           rd_word;
   logic [233:0]         rd_row;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      accepted = bus.frame_valid_i & bus.uplinkrdy_i;
      trig     = 1'b0;
      unique case (bus.trig_mode_i)
         2'd0:    trig = 1'b1;
         2'd1:    trig = bus.uplinkFEC_i;
         2'd2:    trig = ((bus.frame_data_i[31:0] & bus.match_mask_i) ==
                          (bus.match_value_i & bus.match_mask_i));
         default: trig = 1'b0;
      endcase
      // Arm and abort both pre-empt a write landing in the same cycle.
      wr_en   = accepted && !bus.abort_i && !bus.arm_i &&
                ((state_q == ST_ARMED && trig) || state_q == ST_CAPTURE);
      wr_slot = count_q[FADDR_W-1:0];

      rd_frame  = bus.rd_addr_i[FADDR_W+2:3];
      rd_word   = bus.rd_addr_i[2:0];
      rd_row    = mem_q[rd_frame];
      rd_data_d = '0;
      if ({1'b0, rd_frame} < count_q) begin
         if (rd_word == 3'd7) rd_data_d = {22'b0, rd_row[233:224]};
         else                 rd_data_d = rd_row[{rd_word, 5'b0} +: 32];
      end

      fec_d = fec_q;
      if (bus.clear_cnt_i)                                     fec_d = '0;
      else if (accepted && bus.uplinkFEC_i && fec_q != 16'hFFFF) fec_d = fec_q + 16'd1;

      loss_d = loss_q;
      if (bus.clear_cnt_i)                                       loss_d = '0;
      else if (rdy_q && !bus.uplinkrdy_i && loss_q != 16'hFFFF)  loss_d = loss_q + 16'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else if (bus.abort_i) begin
         state_q <= ST_IDLE;
      end else if (bus.arm_i) begin
         state_q <= ST_ARMED;
         count_q <= '0;
      end else if (wr_en) begin
         count_q <= count_q + 1'b1;
         state_q <= (count_q + 1'b1 == DEPTH_C) ? ST_DONE : ST_CAPTURE;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         rd_data_q <= '0;
         fec_q     <= '0;
         loss_q    <= '0;
         rdy_q     <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         fec_q     <= fec_d;
         loss_q    <= loss_d;
         rdy_q     <= bus.uplinkrdy_i;
      end
   end

   // NOTE: the frame buffer has no reset so it can map onto RAM; slots at or
   // beyond the captured count are masked to zero on read instead.
   always_ff @(posedge S_AXI_ACLK) begin
      if (wr_en) mem_q[wr_slot] <= bus.frame_data_i;
   end

   assign bus.rd_data_o         = rd_data_q;
   assign bus.state_o           = state_q;
   assign bus.frames_captured_o = count_q;
   assign bus.fec_err_cnt_o     = fec_q;
   assign bus.rdy_loss_cnt_o    = loss_q;
endmodule

// File: doc/lpgbt_uplink_frame_capture.md
Name: lpgbt_uplink_frame_capture

Overview:
Downstream consumer of the lpGBT-FPGA uplink frame stream. It captures a triggered burst of up to DEPTH 234-bit uplink user-data frames into an internal buffer, readable as 32-bit words by the AXI register layer. It also maintains saturating FEC-correction and link-ready-loss counters. All inputs are synchronous to S_AXI_ACLK; the instantiating wrapper performs any clk40-to-AXI domain crossing before this block.

Parameters:
DEPTH, 16, number of frames held in the capture buffer (power of two, 1..64)
FADDR_W, $clog2(DEPTH), frame index width (minimum 1)

Ports:
S_AXI_ACLK  in  1  block clock
S_AXI_ARESETN  in  1  reset; synchronous and active-low
frame_valid_i  in  1  one-cycle strobe; frame_data_i and uplinkFEC_i are valid this cycle
frame_data_i  in  234  uplink user-data frame
uplinkrdy_i  in  1  uplink-ready level
uplinkFEC_i  in  1  FEC-corrected flag for the current frame
arm_i  in  1  pulse: arm a new capture
abort_i  in  1  pulse: return to IDLE
trig_mode_i  in  2  0=immediate, 1=on FEC flag, 2=pattern match, 3=reserved (never triggers)
match_mask_i  in  32  mask applied to frame_data_i[31:0]
match_value_i  in  32  compare value
clear_cnt_i  in  1  pulse: zero both counters
rd_addr_i  in  FADDR_W+3  word address {frame index, word index[2:0]}
rd_data_o  out  32  read data, 1-cycle latency
state_o  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE
frames_captured_o  out  FADDR_W+1  frames written since the last arm
fec_err_cnt_o  out  16  saturating FEC-correction count
rdy_loss_cnt_o  out  16  saturating count of uplinkrdy_i falling edges

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge): state IDLE, frames_captured_o=0, both counters=0, rd_data_o=0, internal rdy_q=0. Buffer contents are not reset.
- Accepted frame: frame_valid_i=1 and uplinkrdy_i=1. Frames with uplinkrdy_i=0 are never written and never counted as FEC events.
- Trigger condition on an accepted frame:
  - mode 0: always true.
  - mode 1: true when uplinkFEC_i=1.
  - mode 2: true when (frame_data_i[31:0] & match_mask_i) == (match_value_i & match_mask_i).
  - mode 3: never true.
- FSM:
  - IDLE: waits for arm_i.
  - arm_i in any state: go to ARMED, frames_captured=0.
  - ARMED: an accepted frame meeting the trigger is written to slot 0 and frames_captured becomes 1. Next state is CAPTURE, or DONE if DEPTH=1.
  - CAPTURE: every accepted frame is written to slot frames_captured, which then increments. The write that makes frames_captured=DEPTH moves the FSM to DONE.
  - DONE: holds until arm_i or abort_i.
  - abort_i in any state: go to IDLE, frames_captured and buffer contents retained.
  - arm_i and abort_i in the same cycle: abort wins.
  - arm_i in the same cycle as an accepted frame: the frame is not written; the FSM enters ARMED with count 0.
- The trigger frame itself is captured; there is no pre-trigger history.
- Readout, registered on every cycle:
  - frame f = rd_addr_i[FADDR_W+2:3], word w = rd_addr_i[2:0].
  - w=0..6 returns frame bits [32w+31:32w].
  - w=7 returns {22'b0, bits[233:224]}.
  - f >= frames_captured_o returns 0.
  - Reads are legal in any state. Reading a slot in the same cycle it is written returns the old content or 0 (per the f>=count rule); the new data is visible from the next cycle.
- fec_err_cnt: +1 on every accepted frame with uplinkFEC_i=1, in every FSM state.
- rdy_loss_cnt: +1 when rdy_q=1 and uplinkrdy_i=0, where rdy_q is uplinkrdy_i delayed one cycle.
- Both counters saturate at 0xFFFF. clear_cnt_i sets both to 0 and wins over a simultaneous increment.
- Outputs are registered; state_o and frames_captured_o reflect the current register values.
- Buffer: DEPTH×234 flops or distributed RAM with a single write port and a registered read.

Test Plan:
1. Reset, then arm_i, mode 0, 20 accepted frames with data[31:0]=k (k=0..19), DEPTH=16 -> state_o goes 1,2,...,3; frames_captured_o=16; reading rd_addr {5,0} returns 5; frames 16..19 are dropped.
2. Mode 2, mask=0xFF, value=0xA5, frames with data[7:0]=0x00,0x11,0xA5,0x01 -> the trigger fires on the third frame; frame 0 reads 0x000000A5, frame 1 reads 0x01; frames_captured_o=2; state stays CAPTURE.
3. frame_data_i bits[233:224]=0x3FF, others 0, mode 0 -> word 7 of frame 0 reads 0x000003FF; word 6 reads 0; rd_addr {15,7} reads 0 while frames_captured_o=1.
4. uplinkrdy_i toggles 1→0→1→0 with frame_valid_i high throughout, uplinkFEC_i=1 -> rdy_loss_cnt_o=2; fec_err_cnt_o counts only cycles with uplinkrdy_i=1; no buffer writes occur while ready is low.
5. Force fec_err_cnt to 0xFFFE, then send 3 FEC frames -> reads 0xFFFF; clear_cnt_i coincident with an FEC frame -> reads 0.
6. Mid-CAPTURE with frames_captured=7: assert arm_i and abort_i together -> state_o=0 and frames_captured_o stays 7. Then arm_i alone -> state_o=1, frames_captured_o=0. Then assert S_AXI_ARESETN=0 during CAPTURE -> state_o=0 and all counters 0 on the next edge.
